// File: rtl/ram_bus_responder.sv
// ram_bus_responder: word-organised RAM on an Avalon-style bus with byte-enabled writes and
// programmable wait-state insertion through waitrequest. Single master.
//
// Ports:
//   clk            in   clock, all state on posedge
//   reset          in   synchronous active-low reset
//   address        in   [31:0] byte address
//   write / read   in   transfer requests
//   waitrequest    out  1 = request not accepted this cycle
//   writedata      in   [31:0] write data
//   byteenable     in   [3:0] lane enables, bit i -> writedata[8i+7:8i]
//   readdata       out  [31:0] registered read data, valid the cycle after an accepted read
//   protocol_error out  sticky flag for illegal requests
//
// RAM contents are not cleared by reset; words that were never written read as unknown.

module ram_bus_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter bit          RANDOM_WAIT = 1'b0,
  parameter int unsigned WAIT_BITS   = 2,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        write,
  input  logic        read,
  output logic        waitrequest,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        protocol_error
);

  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_MASK = 4'((1 << WAIT_BITS) - 1);

  typedef enum logic {
    StIdle,
    StStall
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_d;
  logic [7:0]        r_lfsr;
  logic [31:0]       r_readdata;
  logic              r_perr;
  logic [31:0]       r_mem [DEPTH];

  logic              w_req;
  logic              w_accept;
  logic              w_illegal;
  logic              w_in_range;
  logic [3:0]        w_stall;
  logic [31:0]       w_offset;
  logic [31:0]       w_word;
  logic [IDX_W-1:0]  w_idx;
  logic              w_lfsr_fb;

  assign w_req     = read | write;
  assign w_stall   = RANDOM_WAIT ? (r_lfsr[3:0] & WAIT_MASK) : 4'(WAIT_CYCLES);

  // Unsigned 32-bit arithmetic: addresses below the base are excluded explicitly so the
  // wrapped offset can never alias back into the window.
  assign w_offset   = address - BASE_ADDR;
  assign w_word     = w_offset >> 2;
  assign w_in_range = (address >= BASE_ADDR) && (w_word < DEPTH);
  assign w_idx      = w_word[IDX_W-1:0];
  assign w_illegal  = (read & write) | (address[1:0] != 2'b00);

  // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB
  assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_accept    = 1'b0;
    waitrequest = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_req) begin
          if (w_stall == 4'd0) begin
            w_accept = 1'b1;
          end else begin
            waitrequest = 1'b1;
            w_cnt_d     = w_stall - 4'd1;
            w_state_d   = StStall;
          end
        end
      end
      StStall: begin
        if (!w_req) begin
          // Master withdrew the request: drop it without touching the RAM.
          w_state_d = StIdle;
        end else if (r_cnt != 4'd0) begin
          waitrequest = 1'b1;
          w_cnt_d     = r_cnt - 4'd1;
        end else begin
          w_accept  = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (!reset) begin
      waitrequest = 1'b1;
      w_accept    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_cnt      <= 4'd0;
      r_lfsr     <= LFSR_SEED;
      r_readdata <= 32'd0;
      r_perr     <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_accept) begin
        r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        if (w_illegal) begin
          r_perr <= 1'b1;
        end else if (read) begin
          r_readdata <= w_in_range ? r_mem[w_idx] : 32'd0;
        end
      end
    end
  end

  // RAM array has no reset; w_accept is already forced low while reset is asserted.
  always_ff @(posedge clk) begin
    if (w_accept && write && !w_illegal && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) begin
          r_mem[w_idx][8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end

  assign readdata       = r_readdata;
  assign protocol_error = r_perr;

endmodule
